// File: rtl/vga_pkg.sv
// Shared VGA 800x600 timing constants and the lock FSM state type,
// used by the sync decoder and the timing generators alike.
package vga_pkg;

   localparam int H_TOTAL    = 1056;
   localparam int HS_START   = 840;
   localparam int V_TOTAL    = 628;
   localparam int VS_START   = 601;
   localparam int LOCK_LINES = 4;

   typedef enum logic [1:0] {
      UNLOCKED,
      ACQUIRE,
      LOCKED
   } lock_state_t;

   function automatic logic [10:0] wrap_inc(input logic [10:0] v, input logic [10:0] last);
      return (v == last) ? 11'd0 : v + 11'd1;
   endfunction

endpackage

// File: rtl/vga_edge_det.sv
// One-flop delay plus rising-edge detect for a signal already
// synchronous to the clock.
module vga_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic sig_d,
   output logic rise
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_d <= 1'b0;
      else        sig_d <= sig;
   end

   assign rise = sig & ~sig_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from hsync/vsync, measures the line period
// and tracks lock to nominal 800x600 timing.
module vga_sync_decoder
   import vga_pkg::*;
(
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic [11:0] line_len,
   output logic        locked,
   output logic        sync_err
);

   localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
   localparam logic [11:0] H_PERIOD  = 12'(H_TOTAL);
   localparam logic [11:0] TIMEOUT   = 12'(2 * H_TOTAL - 1);
   localparam logic [2:0]  GOOD_LAST = 3'(LOCK_LINES - 1);

   logic        hsync_d, vsync_d;
   logic        hs_edge, vs_edge;
   logic        vs_pend;
   logic [11:0] per_cnt;
   logic [11:0] period;
   logic        period_ok;
   logic        timeout;
   logic [2:0]  good_cnt;
   lock_state_t state;
   logic        unused_d;

   vga_edge_det u_hs_det (
      .clk   (pclk),
      .rst_n (rst_n),
      .sig   (hsync),
      .sig_d (hsync_d),
      .rise  (hs_edge)
   );

   vga_edge_det u_vs_det (
      .clk   (pclk),
      .rst_n (rst_n),
      .sig   (vsync),
      .sig_d (vsync_d),
      .rise  (vs_edge)
   );

   assign unused_d  = hsync_d ^ vsync_d;
   assign period    = per_cnt + 12'd1;
   assign period_ok = (period == H_PERIOD);
   assign timeout   = (per_cnt == TIMEOUT);

   // Position and period counters; a vsync edge in the same cycle as hsync counts as pending.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hcount   <= 11'd0;
         vcount   <= 11'd0;
         vs_pend  <= 1'b0;
         per_cnt  <= 12'd0;
         line_len <= 12'd0;
      end else if (hs_edge) begin
         hcount   <= 11'(HS_START);
         per_cnt  <= 12'd0;
         line_len <= period;
         vs_pend  <= 1'b0;
         if (vs_pend || vs_edge) vcount <= 11'(VS_START);
         else                    vcount <= wrap_inc(vcount, V_LAST);
      end else begin
         hcount <= wrap_inc(hcount, H_LAST);
         if (per_cnt != 12'hFFF) per_cnt <= per_cnt + 12'd1;
         if (vs_edge)            vs_pend <= 1'b1;
         if (hcount == H_LAST)   vcount  <= wrap_inc(vcount, V_LAST);
      end
   end

   // Lock FSM; an hsync edge always wins over a coincident timeout.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= UNLOCKED;
         good_cnt <= 3'd0;
         locked   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         if (hs_edge) begin
            case (state)
               UNLOCKED: begin
                  state    <= ACQUIRE;
                  good_cnt <= 3'd0;
               end
               ACQUIRE: begin
                  if (!period_ok) begin
                     good_cnt <= 3'd0;
                  end else begin
                     good_cnt <= good_cnt + 3'd1;
                     if (good_cnt == GOOD_LAST) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (!period_ok) begin
                     state    <= UNLOCKED;
                     locked   <= 1'b0;
                     sync_err <= 1'b1;
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  locked <= 1'b0;
               end
            endcase
         end else if (timeout) begin
            if (state == LOCKED) sync_err <= 1'b1;
            state  <= UNLOCKED;
            locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: table of hsync lines with expected
// lock/period/vcount at each hsync edge, plus timeout and reset sequences.
module tb_vga_sync_decoder;

   logic        pclk;
   logic        rst_n;
   logic        hsync;
   logic        vsync;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic [11:0] line_len;
   logic        locked;
   logic        sync_err;

   vga_sync_decoder dut (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .hsync    (hsync),
      .vsync    (vsync),
      .hcount   (hcount),
      .vcount   (vcount),
      .line_len (line_len),
      .locked   (locked),
      .sync_err (sync_err)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      int len;    // cycles from this line's hsync rise to the next
      int vmode;  // 0 vsync low, 1 vsync rises with hsync, 2 vsync rises mid-line
      int lk;     // expected locked right after this edge
      int ll;     // expected line_len (-1: not checked)
      int vc;     // expected vcount (-1: not checked)
      int err;    // expected sync_err right after this edge
   } vec_t;

   vec_t tab[$];
   int   n_cmp;
   int   n_bad;
   int   err_pulses;

   function automatic vec_t mk(int len, int vmode, int lk, int ll, int vc, int err);
      vec_t v;
      v.len = len; v.vmode = vmode; v.lk = lk; v.ll = ll; v.vc = vc; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
      err_pulses += int'(sync_err);
   endtask

   task automatic do_line(input int idx);
      vec_t v;
      v = tab[idx];
      hsync = 1'b1;
      vsync = (v.vmode == 1);
      tick();
      chk("hcount_at_edge", idx, int'(hcount), 840);
      chk("locked", idx, int'(locked), v.lk);
      chk("sync_err", idx, int'(sync_err), v.err);
      if (v.ll >= 0) chk("line_len", idx, int'(line_len), v.ll);
      if (v.vc >= 0) chk("vcount", idx, int'(vcount), v.vc);
      for (int i = 1; i < v.len; i++) begin
         if (i == 8) hsync = 1'b0;
         if (v.vmode == 2 && i == 100) vsync = 1'b1;
         tick();
      end
      chk("hcount_end_of_line", idx, int'(hcount), (840 + v.len - 1) % 1056);
   endtask

   task automatic run_tab(input int first, input int last);
      for (int k = first; k <= last; k++) do_line(k);
   endtask

   initial begin
      int n;
      int hmax;
      int saw_zero;

      n_cmp = 0; n_bad = 0; err_pulses = 0;
      rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0;

      // Phase A (0..12): lock, vsync coincident and mid-line, short line, re-lock
      tab.push_back(mk(1056, 0, 0,   -1,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 1, 1056,  -1, 0));
      tab.push_back(mk(1056, 1, 1, 1056, 601, 0));
      tab.push_back(mk(1000, 0, 1, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1000,  -1, 1));
      tab.push_back(mk(1056, 2, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056, 601, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 1, 1056,  -1, 0));
      // Phase C (13..20): acquire with periods 1056,1056,1057,1056 x4
      tab.push_back(mk(1056, 0, 0,   -1,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1057, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1057,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 1, 1056,  -1, 0));
      // Phase E (21..25): lock after mid-line reset needs 1+4 edges
      tab.push_back(mk(1056, 0, 0,   -1,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 0, 1056,  -1, 0));
      tab.push_back(mk(1056, 0, 1, 1056,  -1, 0));

      repeat (3) tick();
      chk("rst_hcount", 0, int'(hcount), 0);
      chk("rst_vcount", 0, int'(vcount), 0);
      chk("rst_line_len", 0, int'(line_len), 0);
      chk("rst_locked", 0, int'(locked), 0);
      chk("rst_sync_err", 0, int'(sync_err), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      run_tab(0, 12);
      chk("err_pulses_A", 0, err_pulses, 1);

      // Phase B: hsync held low while locked
      n = 0;
      while (n < 3000 && !sync_err) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 0, n, 1057);
      chk("timeout_locked", 0, int'(locked), 0);
      chk("timeout_hcount", 0, int'(hcount), 840);
      chk("err_pulses_B", 0, err_pulses, 2);
      hmax = 0; saw_zero = 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (int'(hcount) > hmax) hmax = int'(hcount);
         if (hcount == 11'd0) saw_zero = 1;
      end
      chk("free_run_hmax", 0, hmax, 1055);
      chk("free_run_wrap", 0, saw_zero, 1);
      chk("err_pulses_B2", 0, err_pulses, 2);

      run_tab(13, 20);
      chk("err_pulses_C", 0, err_pulses, 2);

      // Phase D: reset mid-line while locked
      hsync = 1'b1;
      tick();
      chk("pre_reset_locked", 0, int'(locked), 1);
      for (int i = 1; i < 300; i++) begin
         if (i == 8) hsync = 1'b0;
         tick();
      end
      rst_n = 1'b0;
      #2;
      chk("async_rst_hcount", 0, int'(hcount), 0);
      chk("async_rst_vcount", 0, int'(vcount), 0);
      chk("async_rst_line_len", 0, int'(line_len), 0);
      chk("async_rst_locked", 0, int'(locked), 0);
      chk("async_rst_sync_err", 0, int'(sync_err), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      run_tab(21, 25);
      chk("err_pulses_E", 0, err_pulses, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
